led_flash_driver: RTL and testbench
===================================

LED_FLASH_DRIVER -- requirements
Module: led_flash_driver

Interface
REQ-001 Parameter k_FLASH_CYCLES, default 1250000, LED-on time per flash (50 ms at 25 MHz).
REQ-002 Parameter k_GAP_CYCLES, default 1250000, forced LED-off time after each flash.
REQ-003 Parameter k_BLINK_HALF, default 6250000, blink half-period (250 ms at 25 MHz).
REQ-004 Parameter k_LED_ACTIVE_LOW, default 0, inverts o_LED when 1.
REQ-005 i_Clk  input  1  sole clock, rising edge.
REQ-006 i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-007 i_Mode  input  2  00 off, 01 steady on, 10 blink, 11 event flash.
REQ-008 i_Event  input  1  single-cycle event pulse, synchronous to i_Clk, typically a debounced switch edge.
REQ-009 o_LED  output  1  registered LED drive, polarity set by k_LED_ACTIVE_LOW.
REQ-010 o_Busy  output  1  high while the flash FSM is in FLASH or GAP.

Function
REQ-011 o_LED SHALL be registered; it reflects an i_Mode change one cycle after the edge at which the change is sampled.
REQ-012 Mode 00 SHALL hold o_LED inactive; mode 01 SHALL hold o_LED active.
REQ-013 Mode 10 SHALL drive o_LED active in the first cycle after entry, then toggle every k_BLINK_HALF cycles; the blink phase restarts on every entry into mode 10.
REQ-014 Mode 11 SHALL use FSM states IDLE, FLASH, GAP; all other modes force IDLE.
REQ-015 IDLE -> FLASH when i_Event=1 is sampled; o_LED is active from the next cycle for exactly k_FLASH_CYCLES cycles.
REQ-016 FLASH -> GAP after k_FLASH_CYCLES cycles; o_LED is inactive for exactly k_GAP_CYCLES cycles.
REQ-017 GAP -> FLASH if a pending event exists, otherwise GAP -> IDLE.
REQ-018 A mode change away from 11 during FLASH or GAP SHALL abort the flash, discard pending events, and enter IDLE at the same edge.
REQ-019 The timer width SHALL cover the largest of the three cycle parameters; the timer never wraps and reloads on every state entry.
REQ-020 A parameter value of 0 SHALL be treated as 1.

Reset
REQ-021 i_Rst_L low SHALL asynchronously force the following: state IDLE, timer 0, pending 0, blink phase 0, o_Busy 0, o_LED inactive (0, or 1 if k_LED_ACTIVE_LOW).
REQ-022 Reset SHALL be released synchronously internally; the first i_Event is honoured on the second edge after deassertion.
REQ-023 Reset asserted mid-flash SHALL take effect immediately; no flash resumes after release.

Configuration
REQ-024 Macro LED_FLASH_QUEUE_EN defined: events sampled in FLASH or GAP increment a 4-bit pending counter that saturates at 15; each GAP -> FLASH transition decrements it.
REQ-025 With LED_FLASH_QUEUE_EN, an event coinciding with the GAP -> FLASH decrement SHALL leave pending unchanged (net zero).
REQ-026 LED_FLASH_QUEUE_EN undefined: events in FLASH or GAP are dropped, pending is constant 0, and GAP always returns to IDLE.

Structure
REQ-027 A shared package SHALL hold the i_Mode encodings, the FSM state enum, and the pending-counter width constant.
REQ-028 Sub-module cycle_timer SHALL provide the loadable down-counter with a done flag; it is shared by the flash, gap and blink timing.

Verification (k_FLASH_CYCLES=4, k_GAP_CYCLES=3, k_BLINK_HALF=5)
REQ-029 Reset test: i_Rst_L low mid-FLASH -> o_LED=0 and o_Busy=0 with no clock edge; after release and no event, o_LED stays 0.
REQ-030 Single flash test: mode 11, one i_Event pulse at edge N -> o_LED=1 for edges N+1..N+4, o_LED=0 for N+5..N+7, o_Busy falls at N+8.
REQ-031 Queued flashes (macro on): three events during the first FLASH -> four flashes back-to-back at 4 on / 3 off, then IDLE; with 20 events, pending saturates at 15.
REQ-032 Queued events (macro off): the same three events -> exactly one flash.
REQ-033 Blink test: switch to mode 10 -> o_LED is 1 for 5 cycles, 0 for 5 cycles, and so on; switching to 00 gives o_LED=0 on the next cycle.
REQ-034 Abort test: mode changed from 11 to 01 mid-GAP with pending=2 -> o_LED=1 the next cycle, o_Busy=0, and returning to 11 produces no flash without a new event.

Source files
------------

// File: rtl/led_flash_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_flash_driver_pkg
// Description : Shared definitions for the LED flash driver: mode encodings,
//               flash FSM states, pending-counter width and cycle helpers.
// Revision    : 1.0  initial release
// ============================================================================
package led_flash_driver_pkg;

  // Operating modes presented on i_Mode
  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_FLASH = 2'b11
  } mode_e;

  // Event-flash state machine
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FLASH = 2'b01,
    ST_GAP   = 2'b10
  } flash_state_e;

  // Pending-event counter (only used when queueing is built in)
  localparam int                PEND_W   = 4;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // A configured duration of zero behaves as a single cycle
  function automatic int eff_cycles(input int cycles);
    return (cycles < 1) ? 1 : cycles;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_flash_driver_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : cycle_timer
// Description : Loadable down-counter with a done flag. Stops at zero (never
//               wraps); done is high whenever the count has reached zero.
// Revision    : 1.0  initial release
// ============================================================================
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load has priority; otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/led_flash_driver.sv
`default_nettype none
// ============================================================================
// Module      : led_flash_driver
// Description : LED driver with off / steady / blink / event-flash modes.
//               Event flashes are FLASH_CYCLES on followed by GAP_CYCLES off.
//               Build option LED_FLASH_QUEUE_EN: events arriving during a
//               flash or gap are queued (saturating at 15) and replayed
//               back-to-back; without it such events are dropped.
// Revision    : 1.0  initial release
// ============================================================================
module led_flash_driver
  import led_flash_driver_pkg::*;
#(
  parameter int k_FLASH_CYCLES   = 1250000,
  parameter int k_GAP_CYCLES     = 1250000,
  parameter int k_BLINK_HALF     = 6250000,
  parameter int k_LED_ACTIVE_LOW = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [1:0] i_Mode,
  input  logic       i_Event,
  output logic       o_LED,
  output logic       o_Busy
);

  localparam int FLASH_EFF = eff_cycles(k_FLASH_CYCLES);
  localparam int GAP_EFF   = eff_cycles(k_GAP_CYCLES);
  localparam int BLINK_EFF = eff_cycles(k_BLINK_HALF);
  localparam int MAX_EFF   = max3(FLASH_EFF, GAP_EFF, BLINK_EFF);
  localparam int TIMER_W   = $clog2(MAX_EFF + 1);

  // Timer counts load..0 and fires on zero, so load duration-1
  localparam logic [TIMER_W-1:0] FLASH_LOAD = TIMER_W'(FLASH_EFF - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_EFF - 1);
  localparam logic [TIMER_W-1:0] BLINK_LOAD = TIMER_W'(BLINK_EFF - 1);
  localparam logic               LED_OFF    = (k_LED_ACTIVE_LOW != 0);

`ifdef LED_FLASH_QUEUE_EN
  localparam bit QUEUE_EN = 1'b1;
`else
  localparam bit QUEUE_EN = 1'b0;
`endif

  mode_e              mode;
  mode_e              mode_q;
  flash_state_e       state;
  flash_state_e       next_state;
  logic               rst_sync_n;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_done;
  logic               blink;
  logic               blink_next;
  logic               led_on;
  logic               led_q;
  logic [PEND_W-1:0]  pending;

  assign mode = mode_e'(i_Mode);

  // Assert asynchronously, release on the following clock edge so the core
  // leaves reset cleanly on the second edge after i_Rst_L rises
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) rst_sync_n <= 1'b0;
    else          rst_sync_n <= 1'b1;
  end

  cycle_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk      (i_Clk),
    .rst_n    (rst_sync_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Flash state register
  always_ff @(posedge i_Clk or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= ST_IDLE;
    else             state <= next_state;
  end

  // Next state, shared timer control, blink phase and LED level
  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    timer_val  = '0;
    blink_next = 1'b0;
    led_on     = 1'b0;

    if (mode != MODE_FLASH) begin
      // Leaving flash mode aborts any flash in progress
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_Event) begin
            next_state = ST_FLASH;
            timer_load = 1'b1;
            timer_val  = FLASH_LOAD;
          end
        end
        ST_FLASH: begin
          if (timer_done) begin
            next_state = ST_GAP;
            timer_load = 1'b1;
            timer_val  = GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (timer_done) begin
            // An event sampled on this very edge also counts as pending
            if (QUEUE_EN && ((pending != '0) || i_Event)) begin
              next_state = ST_FLASH;
              timer_load = 1'b1;
              timer_val  = FLASH_LOAD;
            end else begin
              next_state = ST_IDLE;
            end
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end

    // Blink only runs while the flash FSM is forced idle, so the timer is free
    if (mode == MODE_BLINK) begin
      if (mode_q != MODE_BLINK) begin
        blink_next = 1'b1;
        timer_load = 1'b1;
        timer_val  = BLINK_LOAD;
      end else if (timer_done) begin
        blink_next = ~blink;
        timer_load = 1'b1;
        timer_val  = BLINK_LOAD;
      end else begin
        blink_next = blink;
      end
    end

    case (mode)
      MODE_OFF:   led_on = 1'b0;
      MODE_ON:    led_on = 1'b1;
      MODE_BLINK: led_on = blink_next;
      MODE_FLASH: led_on = (next_state == ST_FLASH);
      default:    led_on = 1'b0;
    endcase
  end

`ifdef LED_FLASH_QUEUE_EN
  logic [PEND_W-1:0] pend_next;

  // Count events seen while busy; each replayed flash consumes one
  always_comb begin
    pend_next = pending;
    if (mode != MODE_FLASH) begin
      pend_next = '0;
    end else if (state == ST_FLASH) begin
      if (i_Event && (pending != PEND_MAX)) pend_next = pending + PEND_W'(1);
    end else if (state == ST_GAP) begin
      if (timer_done) begin
        // Event plus replay nets to zero; a lone event is consumed directly
        if ((pending != '0) && !i_Event) pend_next = pending - PEND_W'(1);
      end else if (i_Event && (pending != PEND_MAX)) begin
        pend_next = pending + PEND_W'(1);
      end
    end
  end

  // Pending-event counter register
  always_ff @(posedge i_Clk or negedge rst_sync_n) begin
    if (!rst_sync_n) pending <= '0;
    else             pending <= pend_next;
  end
`else
  assign pending = '0;
`endif

  // Blink phase, previous mode (for entry detection) and registered LED
  always_ff @(posedge i_Clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      blink  <= 1'b0;
      mode_q <= MODE_OFF;
      led_q  <= LED_OFF;
    end else begin
      blink  <= blink_next;
      mode_q <= mode;
      led_q  <= led_on ^ LED_OFF;
    end
  end

  assign o_LED  = led_q;
  assign o_Busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_led_flash_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_flash_driver
// Description : Self-checking bench for led_flash_driver with short timings
//               (flash 4, gap 3, blink half-period 5). A waveform-level model
//               predicts o_LED / o_Busy every cycle; literal pins at chosen
//               cycles anchor the model to hand-derived values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_led_flash_driver;

  localparam int FLASH = 4;
  localparam int GAP   = 3;
  localparam int HALF  = 5;
`ifdef LED_FLASH_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       ev;
  logic       led;
  logic       busy;

  led_flash_driver #(
    .k_FLASH_CYCLES   (FLASH),
    .k_GAP_CYCLES     (GAP),
    .k_BLINK_HALF     (HALF),
    .k_LED_ACTIVE_LOW (0)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .i_Mode  (mode),
    .i_Event (ev),
    .o_LED   (led),
    .o_Busy  (busy)
  );

  always #5 clk = ~clk;

  // Model: a flash is a queue of upcoming LED levels (FLASH ones, GAP zeros);
  // once it drains, the next edge either replays a pending flash or goes idle.
  bit         m_led  = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_idle = 1'b1;
  bit         m_live = 1'b0;
  int         m_pend = 0;
  int         m_age  = 0;
  logic [1:0] m_prev = 2'b00;
  bit         m_wave[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_led = 1'b0; m_busy = 1'b0; m_idle = 1'b1; m_live = 1'b0;
      m_pend = 0; m_age = 0; m_prev = 2'b00; m_wave.delete();
    end else if (!m_live) begin
      m_live = 1'b1;
    end else begin
      if (mode != 2'b11) begin
        m_wave.delete(); m_idle = 1'b1; m_pend = 0;
      end
      case (mode)
        2'b00: m_led = 1'b0;
        2'b01: m_led = 1'b1;
        2'b10: begin
          if (m_prev != 2'b10) m_age = 0;
          else                 m_age = m_age + 1;
          m_led = ((m_age / HALF) % 2) == 0;
        end
        default: begin
          bit start;
          start = 1'b0;
          if (m_idle) begin
            start = ev;
          end else if (m_wave.size() > 0) begin
            if (QUEUE && ev && m_pend < 15) m_pend = m_pend + 1;
            m_led = m_wave.pop_front();
          end else if (QUEUE && (m_pend > 0 || ev)) begin
            if (!ev) m_pend = m_pend - 1;
            start = 1'b1;
          end else begin
            m_idle = 1'b1;
          end
          if (start) begin
            for (int i = 0; i < FLASH; i++) m_wave.push_back(1'b1);
            for (int i = 0; i < GAP; i++)   m_wave.push_back(1'b0);
            m_led  = m_wave.pop_front();
            m_idle = 1'b0;
          end else if (m_idle) begin
            m_led = 1'b0;
          end
        end
      endcase
      m_busy = !m_idle;
      m_prev = mode;
    end
  end

  // Literal expectations, keyed by compare-cycle number
  int    pin_cyc[$];
  bit    pin_led[$];
  bit    pin_busy[$];
  string pin_name[$];

  int cyc       = 0;
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
  endtask

  // Compare process: every falling edge, model plus any literal pins
  always @(negedge clk) begin
    cyc++;
    check("model_led", led, m_led);
    check("model_busy", busy, m_busy);
    foreach (pin_cyc[i]) begin
      if (pin_cyc[i] == cyc) begin
        check({pin_name[i], "_led"}, led, pin_led[i]);
        check({pin_name[i], "_busy"}, busy, pin_busy[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect levels after the k-th edge from the one just ticked (k=0: that edge)
  task automatic pin(input int k, input bit l, input bit b, input string name);
    pin_cyc.push_back(cyc + 1 + k);
    pin_led.push_back(l);
    pin_busy.push_back(b);
    pin_name.push_back(name);
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'b00; ev = 1'b0;
    repeat (3) tick();
    pin(0, 1'b0, 1'b0, "reset_state");
    rst_n = 1'b1;
    tick(); tick();

    // Single flash: 4 on, 3 off, busy drops after the 8th edge
    mode = 2'b11; tick();
    ev = 1'b1; tick(); ev = 1'b0;
    pin(0, 1'b1, 1'b1, "flash_first");
    pin(3, 1'b1, 1'b1, "flash_last");
    pin(4, 1'b0, 1'b1, "gap_first");
    pin(6, 1'b0, 1'b1, "gap_last");
    pin(7, 1'b0, 1'b0, "flash_done");
    repeat (10) tick();

    // Blink: 5 on, 5 off, then off immediately in mode 00
    mode = 2'b10; tick();
    pin(0, 1'b1, 1'b0, "blink_first");
    pin(4, 1'b1, 1'b0, "blink_on_end");
    pin(5, 1'b0, 1'b0, "blink_off_start");
    pin(9, 1'b0, 1'b0, "blink_off_end");
    pin(10, 1'b1, 1'b0, "blink_on_again");
    repeat (11) tick();
    mode = 2'b00; tick();
    pin(0, 1'b0, 1'b0, "blink_to_off");
    mode = 2'b01; tick();
    pin(0, 1'b1, 1'b0, "steady_on");
    mode = 2'b00; tick();
    pin(0, 1'b0, 1'b0, "steady_off");

    // Three extra events during the first flash
    mode = 2'b11; tick();
    ev = 1'b1; tick();
    if (QUEUE) begin
      for (int k = 0; k < 4; k++) begin
        pin(7 * k, 1'b1, 1'b1, "queued_on");
        pin(7 * k + 4, 1'b0, 1'b1, "queued_gap");
      end
      pin(28, 1'b0, 1'b0, "queued_idle");
    end else begin
      pin(0, 1'b1, 1'b1, "dropped_on");
      pin(7, 1'b0, 1'b0, "dropped_idle");
      pin(10, 1'b0, 1'b0, "dropped_still_idle");
    end
    repeat (3) tick();
    ev = 1'b0;
    repeat (30) tick();

    // Twenty consecutive events: pending saturates at 15
    ev = 1'b1; tick();
    if (QUEUE) begin
      pin(119, 1'b1, 1'b1, "sat_last_flash");
      pin(125, 1'b0, 1'b1, "sat_last_gap");
      pin(126, 1'b0, 1'b0, "sat_idle");
    end else begin
      pin(7, 1'b0, 1'b0, "burst_gap_idle");
      pin(8, 1'b1, 1'b1, "burst_refire");
      pin(23, 1'b0, 1'b0, "burst_end");
    end
    repeat (19) tick();
    ev = 1'b0;
    repeat (130) tick();

    // Abort mid-gap to steady-on, then back to flash mode with no event
    ev = 1'b1; tick(); tick(); tick();
    ev = 1'b0;
    tick(); tick(); tick();
    mode = 2'b01; tick();
    pin(0, 1'b1, 1'b0, "abort_on");
    mode = 2'b11;
    repeat (12) tick();
    pin(0, 1'b0, 1'b0, "abort_no_flash");

    // Asynchronous reset in the middle of a flash
    ev = 1'b1; tick(); ev = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    pin(0, 1'b0, 1'b0, "async_reset");
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    pin(0, 1'b0, 1'b0, "no_resume");

    // Event is ignored on the first edge after release, honoured on the second
    rst_n = 1'b0; tick();
    rst_n = 1'b1; ev = 1'b1;
    tick();
    pin(0, 1'b0, 1'b0, "release_edge1");
    tick(); ev = 1'b0;
    pin(0, 1'b1, 1'b1, "release_edge2");
    repeat (10) tick();

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
